oled_pixel_scanner: RTL
=======================

# oled_pixel_scanner

Frame scanner and SPI serializer for the 96x64 RGB565 OLED panel. It walks pixel coordinates (x, y) in raster order and drives them to the game-screen colour generators. It samples the returned `oled_data` word and shifts it out MSB-first on the panel's 4-wire SPI data interface. Panel power-up and init commands belong to a separate init block. This block handles only pixel data streaming, one frame per `start` pulse.

## Interface
Parameters:
- `WIDTH`, 96, pixels per row; x counts 0..WIDTH-1.
- `HEIGHT`, 64, rows per frame; y counts 0..HEIGHT-1.
- `CLK_DIV`, 4, `clk` cycles per SCLK half-period; legal values are 1 or greater.

Ports:
- `clk`  in  1  system clock. The whole block uses one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to send one frame; ignored while `busy`.
- `oled_data`  in  16  RGB565 colour for the current (x, y), driven combinationally by a game-screen module.
- `x`  out  7  current pixel column, registered.
- `y`  out  6  current pixel row, registered.
- `busy`  out  1  high from the cycle after `start` is accepted until `frame_done`, inclusive.
- `frame_done`  out  1  one-cycle pulse when the last pixel has been shifted out.
- `cs_n`  out  1  SPI chip select, active low.
- `sclk`  out  1  SPI clock; idles high (mode 3).
- `mosi`  out  1  SPI data.
- `dc`  out  1  data/command select; held at 1 (data) at all times.

## Operation
- States: IDLE, LOAD, SHIFT, NEXT, DONE.
- IDLE:
  - outputs are `cs_n`=1, `sclk`=1, `busy`=0.
  - `start`=1 sets x=0, y=0 and moves to LOAD.
- LOAD (1 cycle):
  - `cs_n`=0, `busy`=1.
  - Captures `oled_data` into a 16-bit shift register at the end of the cycle.
  - x and y are already stable for this pixel.
- SHIFT (16 bits, MSB first). Each bit has two phases:
  - low phase, CLK_DIV cycles: `sclk`=0, `mosi`=shift[15].
  - high phase, CLK_DIV cycles: `sclk`=1, `mosi` held.
  - After the high phase, shift left by 1 and increment a 4-bit counter.
  - After bit 15's high phase, go to NEXT.
- NEXT (1 cycle):
  - If x=WIDTH-1 and y=HEIGHT-1, go to DONE.
  - Otherwise: if x=WIDTH-1, set x=0 and y=y+1; else x=x+1. Then go to LOAD.
- DONE (1 cycle): `frame_done`=1, `cs_n`=1, x=0, y=0, then go to IDLE.
- `cs_n` stays low continuously from the first LOAD through the last NEXT; it does not toggle between pixels.
- `start` outside IDLE is ignored and not queued.
- Reset values: state=IDLE, x=0, y=0, `busy`=0, `frame_done`=0, `cs_n`=1, `sclk`=1, `mosi`=0, `dc`=1, shift register=0, bit counter=0, divider counter=0.
- Reset mid-frame: all state returns to reset values immediately and asynchronously. A partially sent word is abandoned, and the frame does not resume after reset.

## Timing
- Take the cycle in which `start` is sampled in IDLE as cycle 0.
- Pixel k (0-based raster index) occupies cycles 1+kP through kP+P, where P = 2+32*CLK_DIV.
  - With default parameters, P = 130.
- `mosi` changes only at the start of a low phase, so data is stable across each SCLK rising edge.
- `frame_done` is high in cycle 1+WIDTH*HEIGHT*P, which is 798721 with default parameters. IDLE follows in the next cycle.
- A `start` in the cycle after `frame_done` is accepted, so frames can run back-to-back.
- `oled_data` must settle within one cycle of an x/y change; the generator is purely combinational.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle. Required: `cs_n`=1, `sclk`=1, `mosi`=0, `dc`=1, x=0, y=0, `busy`=0 with no clock edge.
- Constant colour: tie `oled_data` to 16'h5FFF and pulse `start`.
  - Bits sampled on the first 16 SCLK rising edges must be 0101_1111_1111_1111.
  - Every pixel must repeat that pattern.
  - `frame_done` must fire at cycle 798721.
- Coordinates: with `oled_data` = {3'b0, y, x}, decode the SPI stream. Required: 6144 words in raster order, with (95,0) followed by (0,1) and the last word (95,63).
- Ignored start: pulse `start` at cycles 10 and 5000 during a frame. Required: exactly one `frame_done`, with timing unchanged.
- Mid-frame reset: assert `reset` during pixel 200, release it, then pulse `start`. Required: the new frame begins at (0,0), and a full 6144 words follow with correct timing.
- CLK_DIV=1 build: pulse `start` twice back-to-back. Required: P=34, `sclk` period of 2 cycles, first `frame_done` at cycle 208897, and the second frame accepted in the following cycle.

Source files
------------

// File: rtl/oled_pixel_scanner.sv
// oled_pixel_scanner
// Walks the 96x64 panel in raster order, fetches each RGB565 pixel from the
// combinational colour generator and shifts it out MSB-first over 4-wire SPI
// (mode 3: SCLK idles high, data changes on the falling edge).
//
// Handshake: start is a one-cycle request honoured only in IDLE; a request
// seen while busy is dropped, not queued. busy rises the cycle after the
// request is taken and falls after the frame_done cycle, so a new request in
// the cycle right after frame_done starts the next frame with no gap.
module oled_pixel_scanner #(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] oled_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        busy,
  output logic        frame_done,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic        dc,
  output logic [2:0]  dbg_state
);

  // Divider counter needs at least one bit even when CLK_DIV is 1.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
  localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [6:0]       r_x;
  logic [5:0]       r_y;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_cs_n;
  logic             r_sclk;
  logic             r_mosi;
  logic [15:0]      r_shift;
  logic [3:0]       r_bit;
  logic [DIV_W-1:0] r_div;
  logic             r_high;

  logic w_x_last;
  logic w_y_last;
  logic w_div_end;
  logic w_bit_last;

  assign w_x_last   = (r_x == X_LAST);
  assign w_y_last   = (r_y == Y_LAST);
  assign w_div_end  = (r_div == DIV_LAST);
  assign w_bit_last = (r_bit == 4'd15);

  // Frame sequencer: state, coordinates, SPI pins and status are all
  // registered here so every output changes only on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_x          <= 7'd0;
      r_y          <= 6'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b1;
      r_mosi       <= 1'b0;
      r_shift      <= 16'd0;
      r_bit        <= 4'd0;
      r_div        <= '0;
      r_high       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= 7'd0;
            r_y     <= 6'd0;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_state <= S_LOAD;
          end
        end

        // x/y have been stable for a full cycle, so the generator output
        // is settled; capture it and present the MSB with SCLK low.
        S_LOAD: begin
          r_shift <= oled_data;
          r_mosi  <= oled_data[15];
          r_sclk  <= 1'b0;
          r_div   <= '0;
          r_high  <= 1'b0;
          r_bit   <= 4'd0;
          r_state <= S_SHIFT;
        end

        // Each bit: CLK_DIV cycles low, CLK_DIV cycles high. The next bit
        // is placed on mosi together with the falling edge of SCLK.
        S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_high) begin
              r_high <= 1'b1;
              r_sclk <= 1'b1;
            end else begin
              r_high  <= 1'b0;
              r_shift <= {r_shift[14:0], 1'b0};
              r_bit   <= r_bit + 4'd1;
              if (w_bit_last) begin
                // Last bit done: leave SCLK high through NEXT/LOAD.
                r_state <= S_NEXT;
              end else begin
                r_sclk <= 1'b0;
                r_mosi <= r_shift[14];
              end
            end
          end
        end

        // Advance raster position; cs_n stays low between pixels.
        S_NEXT: begin
          if (w_x_last && w_y_last) begin
            r_x          <= 7'd0;
            r_y          <= 6'd0;
            r_cs_n       <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            if (w_x_last) begin
              r_x <= 7'd0;
              r_y <= r_y + 6'd1;
            end else begin
              r_x <= r_x + 7'd1;
            end
            r_state <= S_LOAD;
          end
        end

        S_DONE: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign cs_n       = r_cs_n;
  assign sclk       = r_sclk;
  assign mosi       = r_mosi;
  assign dc         = 1'b1;
  assign dbg_state  = r_state;

endmodule
